// File: rtl/mem_1r1w_masked_32x64_ctrl.sv
// Controller for a 32x64 1R1W byte-masked SRAM: zero-fill sweep after reset, then
// pass-through writes and pipelined reads with write-first collision merge and a 2-deep response FIFO.
module mem_1r1w_masked_32x64_ctrl (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [4:0]  wr_addr,
  input  logic [63:0] wr_data,
  input  logic [7:0]  wr_mask,
  input  logic        rd_req_valid,
  output logic        rd_req_ready,
  input  logic [4:0]  rd_req_addr,
  output logic        rd_resp_valid,
  input  logic        rd_resp_ready,
  output logic [63:0] rd_resp_data,
  output logic        init_done,
  output logic [4:0]  R0_addr,
  output logic        R0_en,
  input  logic [63:0] R0_data,
  output logic [4:0]  W0_addr,
  output logic        W0_en,
  output logic [63:0] W0_data,
  output logic [7:0]  W0_mask
);
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 64;
  localparam int unsigned MW = 8;
  localparam int unsigned BW = DW / MW;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t        state;
  logic [AW-1:0] cnt;
  logic          run;
  logic          inflight;
  logic [DW-1:0] byp_bits;
  logic [DW-1:0] byp_data;
  logic [DW-1:0] fifo_q [2];
  logic          fifo_wp;
  logic          fifo_rp;
  logic [1:0]    fifo_cnt;
  logic          pop;
  logic [2:0]    occ;
  logic [DW-1:0] wmask_bits;
  logic [DW-1:0] merged;
  logic          collide;

  assign run = (state == RUN);

  // Byte mask expanded to a bit mask
  always_comb begin
    wmask_bits = '0;
    for (int i = 0; i < int'(MW); i++) begin
      wmask_bits[i*BW +: BW] = {BW{wr_mask[i]}};
    end
  end

  // Write port: zero sweep in INIT, pass-through in RUN; held quiet while in reset
  always_comb begin
    W0_en   = 1'b0;
    W0_addr = '0;
    W0_data = '0;
    W0_mask = '0;
    if (reset_n) begin
      if (run) begin
        W0_en   = wr_valid;
        W0_addr = wr_addr;
        W0_data = wr_data;
        W0_mask = wr_mask;
      end else begin
        W0_en   = 1'b1;
        W0_addr = cnt;
        W0_mask = '1;
      end
    end
  end

  // Read admission counts in-flight data plus queued entries, less this cycle's pop
  assign rd_resp_valid = (fifo_cnt != 2'd0);
  assign rd_resp_data  = fifo_q[fifo_rp];
  assign pop           = rd_resp_valid && rd_resp_ready;
  assign occ           = 3'(fifo_cnt) + 3'(inflight) - 3'(pop);
  assign rd_req_ready  = run && (occ < 3'd2);
  assign R0_en         = rd_req_valid && rd_req_ready;
  assign R0_addr       = run ? rd_req_addr : '0;
  assign collide       = R0_en && wr_valid && (wr_addr == rd_req_addr);
  assign merged        = (R0_data & ~byp_bits) | (byp_data & byp_bits);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= INIT;
      cnt       <= '0;
      init_done <= 1'b0;
      wr_ready  <= 1'b0;
      inflight  <= 1'b0;
      byp_bits  <= '0;
      byp_data  <= '0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      fifo_wp   <= 1'b0;
      fifo_rp   <= 1'b0;
      fifo_cnt  <= '0;
    end else begin
      if (state == INIT) begin
        cnt <= cnt + AW'(1);
        if (cnt == '1) begin
          state     <= RUN;
          init_done <= 1'b1;
          wr_ready  <= 1'b1;
        end
      end
      inflight <= R0_en;
      // Capture same-cycle write bytes so the returning read sees them (write-first)
      byp_bits <= collide ? wmask_bits : '0;
      byp_data <= wr_data;
      if (inflight) begin
        fifo_q[fifo_wp] <= merged;
        fifo_wp         <= ~fifo_wp;
      end
      if (pop) begin
        fifo_rp <= ~fifo_rp;
      end
      fifo_cnt <= fifo_cnt + 2'(inflight) - 2'(pop);
    end
  end
endmodule

// File: tb/tb_mem_1r1w_masked_32x64_ctrl.sv
// Self-checking bench: directed vectors, stall/reset sequences and random traffic
// checked against a word-array + expected-response-queue model.
module tb_mem_1r1w_masked_32x64_ctrl;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        wr_valid, wr_ready;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_mask;
  logic        rd_req_valid, rd_req_ready;
  logic [4:0]  rd_req_addr;
  logic        rd_resp_valid, rd_resp_ready;
  logic [63:0] rd_resp_data;
  logic        init_done;
  logic [4:0]  R0_addr;
  logic        R0_en;
  logic [63:0] R0_data;
  logic [4:0]  W0_addr;
  logic        W0_en;
  logic [63:0] W0_data;
  logic [7:0]  W0_mask;

  mem_1r1w_masked_32x64_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready), .rd_resp_data(rd_resp_data),
    .init_done(init_done), .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data),
    .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data), .W0_mask(W0_mask)
  );

  always #5 clock = ~clock;

  // Synchronous-read SRAM with byte-masked write; starts with garbage
  logic [63:0] ram [32];
  bit seeded = 1'b0;
  always @(posedge clock) begin
    if (!seeded) begin
      for (int i = 0; i < 32; i++) ram[i] <= {$urandom(), $urandom()};
      seeded <= 1'b1;
    end else begin
      if (R0_en) R0_data <= ram[R0_addr];
      if (W0_en)
        for (int i = 0; i < 8; i++)
          if (W0_mask[i]) ram[W0_addr][8*i +: 8] <= W0_data[8*i +: 8];
    end
  end

  typedef struct { logic [63:0] data; int vcyc; } resp_t;
  typedef struct {
    bit wv; logic [4:0] wa; logic [63:0] wd; logic [7:0] wm;
    bit rv; logic [4:0] ra; logic [63:0] exp;
  } vec_t;

  int          n_err = 0;
  int          n_chk = 0;
  int          k = 0;
  bit          dut_racc;
  logic [63:0] ref_mem [32];
  resp_t       q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] m);
    logic [63:0] r = old;
    for (int i = 0; i < 8; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // One clock: observe at negedge+1, compare against model, advance model, return at next negedge
  task automatic cycle();
    bit vld_e, pop_e, rdy_e;
    logic [63:0] e;
    resp_t r;
    #1;
    dut_racc = rd_req_valid && rd_req_ready;
    if (reset_n) begin
      k++;
      if (k <= 32) begin
        chk("init_w0_en", 64'(W0_en), 64'd1);
        chk("init_w0_addr", 64'(W0_addr), 64'(k - 1));
        chk("init_w0_data", W0_data, 64'd0);
        chk("init_w0_mask", 64'(W0_mask), 64'hFF);
        chk("init_busy", 64'({init_done, wr_ready, rd_req_ready, R0_en, rd_resp_valid}), 64'd0);
      end else begin
        vld_e = 1'b0;
        if (q.size() > 0) vld_e = (q[0].vcyc <= k);
        pop_e = vld_e && rd_resp_ready;
        rdy_e = (q.size() - int'(pop_e)) < 2;
        chk("init_done", 64'(init_done), 64'd1);
        chk("wr_ready", 64'(wr_ready), 64'd1);
        chk("resp_valid", 64'(rd_resp_valid), 64'(vld_e));
        if (vld_e) chk("resp_data", rd_resp_data, q[0].data);
        chk("req_ready", 64'(rd_req_ready), 64'(rdy_e));
        chk("r0_en", 64'(R0_en), 64'(rd_req_valid && rdy_e));
        if (rd_req_valid) chk("r0_addr", 64'(R0_addr), 64'(rd_req_addr));
        chk("w0_en", 64'(W0_en), 64'(wr_valid));
        if (wr_valid) begin
          chk("w0_data", W0_data, wr_data);
          chk("w0_addr_mask", 64'({W0_addr, W0_mask}), 64'({wr_addr, wr_mask}));
        end
        if (pop_e) void'(q.pop_front());
        if (rd_req_valid && rdy_e) begin
          e = ref_mem[rd_req_addr];
          if (wr_valid && wr_addr == rd_req_addr) e = merge(e, wr_data, wr_mask);
          r.data = e;
          r.vcyc = k + 2;
          q.push_back(r);
        end
        if (wr_valid) ref_mem[wr_addr] = merge(ref_mem[wr_addr], wr_data, wr_mask);
      end
    end
    @(negedge clock);
  endtask

  task automatic idle();
    wr_valid = 1'b0;
    rd_req_valid = 1'b0;
  endtask

  task automatic check_rst();
    #1;
    chk("rst_ctrl", 64'({wr_ready, rd_req_ready, rd_resp_valid, init_done, R0_en, W0_en}), 64'd0);
    chk("rst_resp_data", rd_resp_data, 64'd0);
    chk("rst_w0_data", W0_data, 64'd0);
    chk("rst_addr_mask", 64'({R0_addr, W0_addr, W0_mask}), 64'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    check_rst();
    q.delete();
    k = 0;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 32; i++) ref_mem[i] = 64'd0;
    reset_n = 1'b1;
  endtask

  // Issue one read, check 2-cycle latency and data, then pop it
  task automatic read_check(input string name, input logic [4:0] a, input logic [63:0] exp);
    int w = 0;
    rd_resp_ready = 1'b1;
    rd_req_valid = 1'b1;
    rd_req_addr = a;
    cycle();
    idle();
    while (!rd_resp_valid && w < 10) begin cycle(); w++; end
    chk({name, "_lat"}, 64'(w), 64'd1);
    chk({name, "_data"}, rd_resp_data, exp);
    cycle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v[7];
    int acc, w;
    v[0] = '{0, 5'd0,  64'd0, 8'h00, 1, 5'd7,  64'd0};
    v[1] = '{1, 5'd3,  64'h1122334455667788, 8'h0F, 0, 5'd0, 64'd0};
    v[2] = '{0, 5'd0,  64'd0, 8'h00, 1, 5'd3,  64'h0000000055667788};
    v[3] = '{1, 5'd5,  64'hFFFFFFFFFFFFFFFF, 8'h81, 1, 5'd5, 64'hFF000000000000FF};
    v[4] = '{1, 5'd3,  64'hAAAAAAAAAAAAAAAA, 8'hF0, 1, 5'd3, 64'hAAAAAAAA55667788};
    v[5] = '{0, 5'd0,  64'd0, 8'h00, 1, 5'd5,  64'hFF000000000000FF};
    v[6] = '{1, 5'd31, 64'h0123456789ABCDEF, 8'hFF, 1, 5'd31, 64'h0123456789ABCDEF};

    reset_n = 1'b0;
    idle();
    wr_addr = '0; wr_data = '0; wr_mask = '0; rd_req_addr = '0; rd_resp_ready = 1'b1;
    @(negedge clock);
    do_reset();
    repeat (32) cycle();

    // Directed vectors; first read lands on the first RUN cycle
    for (int i = 0; i < 7; i++) begin
      wr_valid = v[i].wv; wr_addr = v[i].wa; wr_data = v[i].wd; wr_mask = v[i].wm;
      rd_req_valid = v[i].rv; rd_req_addr = v[i].ra; rd_resp_ready = 1'b1;
      cycle();
      idle();
      if (v[i].rv) begin
        w = 0;
        while (!rd_resp_valid && w < 10) begin cycle(); w++; end
        chk($sformatf("vec%0d_lat", i), 64'(w), 64'd1);
        chk($sformatf("vec%0d_data", i), rd_resp_data, v[i].exp);
        cycle();
      end
    end

    // A write after the read was issued must not leak into it
    rd_req_valid = 1'b1; rd_req_addr = 5'd3;
    cycle();
    idle();
    wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 64'hDEADBEEFCAFEF00D; wr_mask = 8'hFF;
    cycle();
    idle();
    chk("rbw_valid", 64'(rd_resp_valid), 64'd1);
    chk("rbw_data", rd_resp_data, 64'hAAAAAAAA55667788);
    cycle();
    read_check("rbw_after", 5'd3, 64'hDEADBEEFCAFEF00D);

    // Backpressure: only two reads admitted, then one per cycle once released
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = 5'(10 + i); wr_data = {2{32'(i * 32'h01010101 + 32'h1000)}}; wr_mask = 8'hFF;
      cycle();
    end
    idle();
    rd_resp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      rd_req_valid = 1'b1; rd_req_addr = 5'(10 + acc);
      cycle();
      if (dut_racc) acc++;
    end
    chk("stall_accepts", 64'(acc), 64'd2);
    chk("stall_ready", 64'(rd_req_ready), 64'd0);
    chk("stall_hold_data", rd_resp_data, ref_mem[10]);
    rd_resp_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      rd_req_valid = 1'b1; rd_req_addr = 5'(10 + (i % 4));
      cycle();
      if (dut_racc) acc++;
    end
    chk("sustain_accepts", 64'(acc), 64'd10);
    idle();
    w = 0;
    while (q.size() > 0 && w < 10) begin cycle(); w++; end
    chk("drain1", 64'(q.size()), 64'd0);

    // Random traffic with address clustering to provoke collisions
    for (int i = 0; i < 1500; i++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom());
      wr_data = {$urandom(), $urandom()};
      wr_mask = 8'($urandom());
      rd_req_valid = ($urandom_range(0, 3) != 0);
      rd_req_addr = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom());
      rd_resp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    idle();
    rd_resp_ready = 1'b1;
    w = 0;
    while (q.size() > 0 && w < 10) begin cycle(); w++; end
    chk("drain2", 64'(q.size()), 64'd0);

    // Reset with two responses queued
    rd_resp_ready = 1'b0;
    acc = 0; w = 0;
    while (acc < 2 && w < 20) begin
      rd_req_valid = 1'b1; rd_req_addr = 5'($urandom());
      cycle();
      if (dut_racc) acc++;
      w++;
    end
    idle();
    repeat (3) cycle();
    chk("queued_valid", 64'(rd_resp_valid), 64'd1);
    do_reset();
    rd_resp_ready = 1'b1;

    // Reset again mid-sweep at c=12; sweep must restart from 0
    repeat (12) cycle();
    #1;
    chk("midinit_addr", 64'(W0_addr), 64'd12);
    do_reset();
    repeat (32) cycle();
    read_check("post_rst_rd3", 5'd3, 64'd0);
    read_check("post_rst_rd7", 5'd7, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
